// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the
// enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers. It resolves load-use hazards, EX redirects and
// multi-cycle data-memory accesses, and a watchdog traps an access that
// never completes.
//
// Parameters:
//   MEM_TIMEOUT   consecutive memory-stall cycles tolerated before trapping
//                 (0 disables the watchdog, 8-bit range)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs1, id_rs2             source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2   ID instruction actually reads rs1 / rs2
//   ex_rd, ex_memread          destination / is-load of the instruction in EX
//   ex_redirect                EX resolves a taken branch or JALR
//   mem_req, mem_ready         data-memory access in MEM and its completion
//   pc_en .. memwb_en          register load enables (combinational)
//   ifid_flush .. memwb_flush  load a bubble instead of data (combinational)
//   mem_err                    sticky watchdog trap (registered)
//   stall_cycles, flush_events performance counters (registered)
//
// Build option:
//   HAZARD_PERF_EN  when defined, the performance counters are implemented;
//                   otherwise they are tied to zero.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    logic       mem_err_q;
    logic       mem_err_d;

    logic memstall_s;
    logic loaduse_s;
    logic active_s;

    // Hazard detection terms shared by the FSM, the outputs and the counters.
    always_comb begin
        memstall_s = mem_req & ~mem_ready;
        loaduse_s  = ex_memread & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));
        // Hazard handling is live only outside reset and outside ERROR.
        active_s   = ~reset & ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT));
    end

    // State register, watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next-state logic: memory wait tracking and watchdog trap.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (memstall_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (memstall_s) begin
                    // wait_cnt holds the number of stall cycles already
                    // completed, so matching TIMEOUT here means this is
                    // stall cycle TIMEOUT+1.
                    if ((TIMEOUT_C != 8'd0) && (wait_cnt_q == TIMEOUT_C)) begin
                        state_d   = ST_ERROR;
                        mem_err_d = 1'b1;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_ERROR: begin
                state_d   = ST_ERROR;
                mem_err_d = 1'b1;
            end
            default: begin
                // Unreachable encoding: fail safe into the trap state.
                state_d   = ST_ERROR;
                mem_err_d = 1'b1;
            end
        endcase
    end

    // Enable/flush outputs: zero-latency response from state and inputs.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            // Freeze everything but let clocked registers take bubbles.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (!active_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
        end else if (memstall_s) begin
            // Freeze the front of the pipe; WB receives bubbles meanwhile.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            // PC loads the target; the two wrong-path instructions die.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (loaduse_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end else begin
            pc_en       = 1'b1;
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    // Saturating performance counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (active_s && (memstall_s || loaduse_s) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        // A redirect is only acted on when no memory stall overrides it.
        if (active_s && ex_redirect && !memstall_s && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = 16'd0;
    assign flush_events = 16'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards: load-use data hazards, control redirects from EX (branch taken / JALR), and multi-cycle data-memory accesses with a ready handshake. A watchdog traps a memory access that never completes.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-stall cycles tolerated before trapping; 0 disables the watchdog; 8-bit range.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  instruction in EX is a load.
- ex_redirect  in  1  EX resolves a taken branch or JALR (Orgate | Jalr).
- mem_req  in  1  instruction in MEM performs a data-memory read or write.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control bits 0) instead of data.
- mem_err  out  1  sticky watchdog trap.
- stall_cycles, flush_events  out  16 each  performance counters (see Configuration).

## Operation
- States: RUN, MEM_WAIT, ERROR. Registered: state, 8-bit wait_cnt, mem_err, counters. All enable/flush outputs are combinational from state and inputs.
- memstall = mem_req & ~mem_ready.
- loaduse = ex_memread & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Default (no hazard): all *_en = 1, all *_flush = 0.
- Priority in RUN/MEM_WAIT: memstall > ex_redirect > loaduse.
- memstall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en = 1, memwb_flush = 1; ifid_flush and idex_flush = 0. Pending redirect/loaduse is evaluated on the release cycle.
- ex_redirect: pc_en = 1 (loads the target), ifid_flush = 1, idex_flush = 1; other enables 1.
- loaduse: pc_en = 0, ifid_en = 0, idex_flush = 1; exmem_en = memwb_en = 1. Lasts exactly one cycle, with no state change.
- Transitions:
  - RUN → MEM_WAIT when memstall, with wait_cnt ← 1.
  - MEM_WAIT & memstall: if MEM_TIMEOUT != 0 and wait_cnt == MEM_TIMEOUT → ERROR; else wait_cnt+1, saturating at 255.
  - MEM_WAIT & ~memstall → RUN; that cycle is a normal RUN cycle (redirect/loaduse apply).
- ERROR: all *_en = 0, all *_flush = 0, mem_err = 1. Left only by reset.
- Reset (while reset = 1): all *_en = 0, ifid_flush = idex_flush = memwb_flush = 1, so registers load bubbles if clocked. On the edge: state ← RUN, wait_cnt ← 0, mem_err ← 0, counters ← 0. Reset mid-MEM_WAIT or in ERROR aborts immediately.

## Timing
- Hazard response is zero-latency (same cycle as the inputs).
- A load followed by a dependent instruction costs exactly 1 bubble.
- A redirect costs 2 bubbles (IF/ID and ID/EX flushed on the same edge).
- A memory access with N cycles of mem_ready low freezes the pipeline for N cycles. It completes in the cycle mem_ready is high.
- Watchdog: with MEM_TIMEOUT = T > 0, the edge ending stall cycle T+1 enters ERROR. mem_err is high from the following cycle.
- mem_req with mem_ready high in the same cycle incurs no stall.

## Configuration
- HAZARD_PERF_EN defined: counters are enabled.
  - stall_cycles increments every cycle with memstall or loaduse in RUN/MEM_WAIT.
  - flush_events increments every cycle ex_redirect is acted on.
  - Both saturate at 16'hFFFF, clear on reset, and hold in ERROR.
- HAZARD_PERF_EN undefined: no counter flops; stall_cycles and flush_events are tied to 0.

## Test plan
- Load-use: ex_memread = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 for 1 cycle → pc_en = 0, ifid_en = 0, idex_flush = 1 in that cycle only; state stays RUN.
- x0 / unused operand: same as load-use but ex_rd = 0, or id_uses_rs1 = 0 → no stall, all enables 1.
- Redirect: ex_redirect = 1 → ifid_flush = idex_flush = 1, pc_en = 1. With loaduse simultaneously true → redirect wins, pc_en = 1.
- Memory wait: mem_req = 1, mem_ready low 3 cycles then high → front enables 0 and memwb_flush = 1 for 3 cycles, then release. If HAZARD_PERF_EN is defined, stall_cycles = 3.
- Watchdog: MEM_TIMEOUT = 4, mem_ready held low → ERROR after the 5th stall cycle, mem_err = 1 and all enables 0. Assert reset 1 cycle → mem_err = 0, state RUN.
- Reset during MEM_WAIT (cycle 2 of a stall) → outputs show reset values that cycle, RUN afterwards, wait_cnt = 0.
